// File: rtl/uart_tx_interface_pong_if.sv
// Bundle of the producer-side write port and the UART_TX handshake used by
// uart_tx_interface_pong. The buffer connects through the slave modport; the
// producer/UART environment connects through the master modport.
interface uart_tx_interface_pong_if #(
  parameter int DEPTH_LOG2 = 2
) ();

  // Producer side
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   count;

  // UART_TX side
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_done_tick;

  modport master (
    output wr_en,
    output wr_data,
    output tx_done_tick,
    input  full,
    input  overflow,
    input  count,
    input  tx_start,
    input  tx_data
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  tx_done_tick,
    output full,
    output overflow,
    output count,
    output tx_start,
    output tx_data
  );

endinterface

// File: rtl/uart_tx_interface_pong.sv
// Transmit-side buffer between the Crypter and UART_TX.
// Bytes are queued in a small circular FIFO and handed to UART_TX one at a
// time: a byte is popped into tx_data, announced with a one-cycle tx_start,
// and the block then waits for tx_done_tick before popping the next one.
// Completion of the end-of-transmission byte is flagged on eot_sent so the
// pong loop can close. All outputs come straight from registers.
module uart_tx_interface_pong #(
  parameter int         DEPTH_LOG2 = 2,
  parameter logic [7:0] EOT_BYTE   = 8'h04
) (
  input  logic                          clk,
  input  logic                          rst,       // asynchronous, active-low
  uart_tx_interface_pong_if.slave       bus,
  output logic                          busy,
  output logic                          eot_sent
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(1'b0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(1'b0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);

  // Transfer sequencer states. LOAD is the single cycle in which tx_start is
  // high; WAIT_DONE holds tx_data stable until UART_TX reports completion.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // FIFO storage and bookkeeping
  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  full_r;
  logic                  overflow_r;

  // Sequencer and registered outputs
  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  tx_start_r;
  logic [7:0]            tx_data_r;
  logic                  busy_r;
  logic                  eot_sent_r;

  // Per-edge events
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic                  done_s;
  logic                  eot_nxt_s;

  // Decode this edge's FIFO events. A write while full is dropped even when a
  // pop frees a slot on the same edge, because fullness is judged on count_r.
  always_comb begin
    push_s    = 1'b0;
    drop_s    = 1'b0;
    pop_s     = 1'b0;
    done_s    = 1'b0;
    eot_nxt_s = 1'b0;
    if (bus.wr_en) begin
      if (full_r) begin
        drop_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    if ((state_r == ST_IDLE) && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if ((state_r == ST_WAIT_DONE) && bus.tx_done_tick) begin
      done_s    = 1'b1;
      eot_nxt_s = (tx_data_r == EOT_BYTE);
    end else begin
      done_s    = 1'b0;
      eot_nxt_s = 1'b0;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next sequencer state; tx_done_tick outside WAIT_DONE has no effect.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage: accepted bytes land at the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Sequencer state and the registered UART-facing outputs. tx_data only
  // changes on a pop, so it stays stable from tx_start until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      eot_sent_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_start_r <= (state_nxt_s == ST_LOAD);
      busy_r     <= (state_nxt_s != ST_IDLE);
      eot_sent_r <= eot_nxt_s;
      if (pop_s) begin
        tx_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign bus.full     = full_r;
  assign bus.overflow = overflow_r;
  assign bus.count    = count_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign busy         = busy_r;
  assign eot_sent     = eot_sent_r;

endmodule

// File: tb/tb_uart_tx_interface_pong.sv
// Bench for uart_tx_interface_pong. A transaction-level reference model
// (byte queue plus a "link busy" flag) predicts every output; expected bytes
// for UART_TX are queued at issue and popped by a monitor on each tx_start.
module tb_uart_tx_interface_pong;

  localparam int         DL    = 2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] EOT   = 8'h04;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic eot_sent;

  uart_tx_interface_pong_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_interface_pong #(.DEPTH_LOG2(DL), .EOT_BYTE(EOT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .eot_sent (eot_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_tx_q[$];
  bit         m_busy  = 1'b0;
  bit         m_over  = 1'b0;
  bit         m_start = 1'b0;
  bit         m_eot   = 1'b0;
  logic [7:0] m_txd   = 8'h00;

  // UART model controls
  int uart_lat   = 10;
  bit uart_stall = 1'b0;
  bit uart_rand  = 1'b0;
  bit stray_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},    32'(bus.count),    32'd0);
    chk({tag, "_full"},     32'(bus.full),     32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
    chk({tag, "_eot_sent"}, 32'(eot_sent),     32'd0);
  endtask

  // Reference model: one byte on the link at a time; a byte is taken as soon
  // as the link is free and the queue is non-empty; the link frees on a done
  // tick after the start cycle; a write to a 4-byte queue is lost.
  initial begin : model
    bit was_busy;
    bit in_start;
    bit full_pre;
    bit do_pop;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_q.delete();
        exp_tx_q.delete();
        m_busy  = 1'b0;
        m_over  = 1'b0;
        m_start = 1'b0;
        m_eot   = 1'b0;
        m_txd   = 8'h00;
      end else begin
        was_busy = m_busy;
        in_start = m_start;
        full_pre = (m_q.size() == DEPTH);
        do_pop   = !was_busy && (m_q.size() != 0);
        m_eot    = 1'b0;
        if (bus.tx_done_tick && was_busy && !in_start) begin
          m_busy = 1'b0;
          m_eot  = (m_txd == EOT);
        end
        m_start = 1'b0;
        if (do_pop) begin
          m_txd = m_q.pop_front();
          exp_tx_q.push_back(m_txd);
          m_busy  = 1'b1;
          m_start = 1'b1;
        end
        if (bus.wr_en) begin
          if (full_pre) m_over = 1'b1;
          else          m_q.push_back(bus.wr_data);
        end
      end
    end
  end

  // Monitor: compare every output against the model once per cycle, and
  // pop the scoreboard whenever the DUT issues a byte.
  initial begin : monitor
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("count",    32'(bus.count),    32'(m_q.size()));
        chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(m_over));
        chk("busy",     32'(busy),         32'(m_busy));
        chk("tx_start", 32'(bus.tx_start), 32'(m_start));
        chk("tx_data",  32'(bus.tx_data),  32'(m_txd));
        chk("eot_sent", 32'(eot_sent),     32'(m_eot));
        if (bus.tx_start) begin
          if (exp_tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_byte: unexpected tx_start with tx_data 0x%0h at %0t", bus.tx_data, $time);
          end else begin
            exp_b = exp_tx_q.pop_front();
            chk("tx_byte", 32'(bus.tx_data), 32'(exp_b));
          end
        end
      end
    end
  end

  // UART_TX model: latches a byte on tx_start, answers with tx_done_tick
  // some cycles later, can be stalled, and can emit stray ticks while idle.
  initial begin : uart
    int rem;
    rem = 0;
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      if (!rst) begin
        rem = 0;
      end else if (bus.tx_start) begin
        rem = uart_rand ? int'($urandom_range(1, 6)) : uart_lat;
      end else if (rem > 0) begin
        if (!uart_stall) begin
          rem--;
          if (rem == 0) bus.tx_done_tick = 1'b1;
        end
      end else if (stray_en && !m_busy && ($urandom_range(0, 7) == 0)) begin
        bus.tx_done_tick = 1'b1;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() == 0 && !m_busy) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!drained) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: queue %0d busy %0d after %0d cycles", tag, m_q.size(), m_busy, budget);
    end
    idle(3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stimulus
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    idle(2);
    check_reset_outputs("por");
    rst = 1'b1;
    idle(2);

    // Single byte while idle
    uart_lat = 4;
    write_byte(8'hA5);
    wait_drain("single", 50);

    // Four-byte burst, slow UART
    uart_lat = 10;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    wait_drain("burst", 200);
    chk("burst_count_end", 32'(bus.count), 32'd0);

    // EOT byte, followed by a normal byte
    uart_lat = 3;
    write_byte(EOT);
    write_byte(8'h5A);
    wait_drain("eot", 60);

    // Stalled UART: one in flight, four queued, sixth write dropped
    uart_stall = 1'b1;
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    write_byte(8'hC4);
    write_byte(8'hC5);
    chk("stall_full", 32'(bus.full), 32'd1);
    chk("stall_overflow_pre", 32'(bus.overflow), 32'd0);
    write_byte(8'hEE);
    idle(2);
    chk("stall_overflow", 32'(bus.overflow), 32'd1);
    uart_stall = 1'b0;
    wait_drain("stall", 200);

    // Reset with three queued and one in flight
    uart_stall = 1'b1;
    write_byte(8'hD1);
    write_byte(8'hD2);
    write_byte(8'hD3);
    write_byte(8'hD4);
    idle(2);
    chk("pre_reset_count", 32'(bus.count), 32'd3);
    chk("pre_reset_busy",  32'(busy),      32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    idle(2);
    rst = 1'b1;
    uart_stall = 1'b0;
    idle(8);

    // Randomised traffic: same-edge push/pop, pointer wrap, stray ticks
    uart_rand = 1'b1;
    stray_en  = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.wr_en   = ($urandom_range(0, 99) < 45);
      bus.wr_data = ($urandom_range(0, 5) == 0) ? EOT : 8'($urandom);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    wait_drain("random", 500);
    stray_en = 1'b0;
    idle(4);

    chk("scoreboard_empty", 32'(exp_tx_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
